// File: rtl/receive_slot_allocator.sv
// receive_slot_allocator: steers each received frame into a free receive-queue slot.
// Build option RECEIVE_SLOT_ALLOCATOR_DROP_EN drops frames instead of stalling when full.
module receive_slot_allocator #(
  parameter int RECEIVE_QUE_SLOTS = 4,
  parameter int MAX_FRAME_BYTES   = 1522
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [8:0]                             rx_data,
  input  logic                                   rx_data_valid,
  output logic                                   rx_ready,
  output logic [8:0]                             slot_write_data,
  output logic [RECEIVE_QUE_SLOTS-1:0]           slot_write_enable,
  output logic [RECEIVE_QUE_SLOTS-1:0]           slot_enable,
  input  logic [RECEIVE_QUE_SLOTS-1:0]           slot_release,
  output logic [$clog2(RECEIVE_QUE_SLOTS+1)-1:0] slots_free,
  output logic [15:0]                            drop_count,
  output logic [15:0]                            truncate_count
);
  localparam int N  = RECEIVE_QUE_SLOTS;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;
  typedef enum logic [1:0] {ST_FREE, ST_FILLING, ST_FULL} slot_t;

  state_t        r_state, w_next;
  slot_t         r_status [N];
  logic [PW-1:0] r_alloc_ptr, r_cur;
  logic [PW-1:0] w_free_idx, w_probe, w_slot, w_ptr_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [N-1:0]  r_done1, r_done2, r_wen;
  logic [8:0]    r_wdata;
  logic [15:0]   r_drop, r_trunc;
  logic [FW-1:0] w_free_cnt;
  logic          w_free_any, w_accept, w_alloc, w_write;
  logic          w_wlast, w_done, w_drop, w_trunc;

  // lowest offset from alloc_ptr wins, so scan offsets high to low
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_probe    = '0;
    w_free_cnt = '0;
    for (int i = 0; i < N; i++)
      if (r_status[i] == ST_FREE) w_free_cnt = w_free_cnt + FW'(1);
    for (int i = N - 1; i >= 0; i--) begin
      w_probe = PW'((int'(r_alloc_ptr) + i) % N);
      if (r_status[w_probe] == ST_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = w_probe;
      end
    end
  end

  assign w_ptr_next = (w_free_idx == PW'(N - 1)) ? '0 : w_free_idx + PW'(1);
  assign w_slot     = (r_state == S_IDLE) ? w_free_idx : r_cur;

  always_comb begin
    w_next       = r_state;
    rx_ready     = 1'b1;
    w_accept     = 1'b0;
    w_alloc      = 1'b0;
    w_write      = 1'b0;
    w_wlast      = rx_data[8];
    w_done       = 1'b0;
    w_drop       = 1'b0;
    w_trunc      = 1'b0;
    w_count_next = r_count;
    unique case (r_state)
      S_IDLE: begin
`ifdef RECEIVE_SLOT_ALLOCATOR_DROP_EN
        rx_ready = 1'b1;
`else
        rx_ready = w_free_any;
`endif
        w_accept = rx_data_valid && rx_ready;
        if (w_accept && w_free_any) begin
          w_alloc      = 1'b1;
          w_write      = 1'b1;
          w_count_next = CW'(1);
          if (rx_data[8]) w_done = 1'b1;
          else            w_next = S_WRITE;
        end else if (w_accept) begin
          w_drop = 1'b1;
          if (!rx_data[8]) w_next = S_DISCARD;
        end
      end
      S_WRITE: begin
        w_accept = rx_data_valid;
        if (w_accept) begin
          w_write      = 1'b1;
          w_count_next = r_count + CW'(1);
          if (rx_data[8]) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else if (w_count_next == CW'(MAX_FRAME_BYTES)) begin
            w_wlast = 1'b1;
            w_done  = 1'b1;
            w_trunc = 1'b1;
            w_next  = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        w_accept = rx_data_valid;
        if (w_accept && rx_data[8]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FULL is delayed two edges so the last byte reaches the FIFO first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_status[i] <= ST_FREE;
      r_alloc_ptr <= '0;
      r_cur       <= '0;
      r_count     <= '0;
      r_done1     <= '0;
      r_done2     <= '0;
      r_wen       <= '0;
      r_wdata     <= '0;
      r_drop      <= '0;
      r_trunc     <= '0;
    end else begin
      r_wen <= '0;
      if (w_write) begin
        r_wen   <= N'(1) << w_slot;
        r_wdata <= {w_wlast, rx_data[7:0]};
      end
      r_done1 <= w_done ? (N'(1) << w_slot) : '0;
      r_done2 <= r_done1;
      r_count <= w_count_next;
      if (w_alloc) begin
        r_cur       <= w_free_idx;
        r_alloc_ptr <= w_ptr_next;
      end
      if (w_drop && r_drop != 16'hFFFF)   r_drop  <= r_drop + 16'd1;
      if (w_trunc && r_trunc != 16'hFFFF) r_trunc <= r_trunc + 16'd1;
      for (int i = 0; i < N; i++) begin
        if (w_alloc && w_free_idx == PW'(i))
          r_status[i] <= ST_FILLING;
        else if (r_done2[i])
          r_status[i] <= ST_FULL;
        else if (slot_release[i] && r_status[i] == ST_FULL)
          r_status[i] <= ST_FREE;
      end
    end
  end

  always_comb begin
    slot_enable = '0;
    for (int i = 0; i < N; i++)
      slot_enable[i] = (r_status[i] == ST_FULL);
  end

  assign slots_free        = w_free_cnt;
  assign slot_write_data   = r_wdata;
  assign slot_write_enable = r_wen;
  assign drop_count        = r_drop;
  assign truncate_count    = r_trunc;

endmodule

// File: doc/receive_slot_allocator.md
# receive_slot_allocator

Front end of the receive queue. It accepts the 9-bit per-port receive byte stream (bit 8 = last byte of frame) and assigns each frame to a free receive-queue slot. Frame bytes go to that slot's write port. When a frame is complete, the slot is marked ready for the downstream receive slot arbiter. The slot is freed when the arbiter reports it drained.

## Interface
Parameters:
- RECEIVE_QUE_SLOTS, default 4 — number of receive-queue slots. Must be ≥2.
- MAX_FRAME_BYTES, default 1522 — longest frame stored. Longer frames are truncated.

Ports:
- clock  input  1  — clock.
- reset_n  input  1  — reset; asynchronous, active-low.
- rx_data  input  9  — [7:0] byte; [8] last byte of frame.
- rx_data_valid  input  1  — rx_data valid. A byte is accepted on an edge where rx_data_valid && rx_ready.
- rx_ready  output  1  — allocator can accept a byte.
- slot_write_data  output  9  — byte plus last flag to the slot FIFOs.
- slot_write_enable  output  RECEIVE_QUE_SLOTS  — one-hot write strobe.
- slot_enable  output  RECEIVE_QUE_SLOTS  — slot holds a complete frame. Feeds the arbiter's enable input.
- slot_release  input  RECEIVE_QUE_SLOTS  — pulse per slot when the arbiter has drained it.
- slots_free  output  $clog2(RECEIVE_QUE_SLOTS+1)  — count of FREE slots.
- drop_count  output  16  — frames discarded for lack of a slot. Saturates at 16'hFFFF.
- truncate_count  output  16  — frames cut at MAX_FRAME_BYTES. Saturates at 16'hFFFF.

## Operation
- Each slot has a registered status:
  - FREE → FILLING: when the slot is allocated.
  - FILLING → FULL: when its last byte is written.
  - FULL → FREE: on slot_release.
- slot_enable[i] = (status[i] == FULL).
- slot_release on a slot that is not FULL is ignored.
- Allocation is round-robin:
  - Search starts at alloc_ptr and takes the first FREE slot (wrapping at RECEIVE_QUE_SLOTS-1 → 0).
  - alloc_ptr becomes the allocated index + 1, with wrap.
- Main FSM:
  - S_IDLE: waits for the first byte of a frame.
    - If a slot is FREE: rx_ready = 1. On acceptance, allocate the slot, write the byte, set byte_count = 1, go to S_WRITE. If the byte has [8] = 1, the slot goes directly to FULL and the FSM stays in S_IDLE.
    - If no slot is FREE: behaviour is set by the Configuration macro.
  - S_WRITE: rx_ready = 1. Each accepted byte is written to the current slot and byte_count increments.
    - A byte with [8] = 1 marks the slot FULL and returns the FSM to S_IDLE.
    - When the accepted byte makes byte_count == MAX_FRAME_BYTES and [8] = 0, the byte is written with [8] forced to 1 and the slot marked FULL. truncate_count increments and the FSM goes to S_DISCARD.
  - S_DISCARD: rx_ready = 1. Bytes are consumed without any write. The byte with [8] = 1 returns the FSM to S_IDLE.
- Width rule: byte_count is $clog2(MAX_FRAME_BYTES+1) bits and never exceeds MAX_FRAME_BYTES.
- Reset (asynchronous, also mid-frame): all of the following reset to 0:
  - slot status (all FREE), state S_IDLE, alloc_ptr, byte_count;
  - outputs slot_write_data, slot_write_enable, slot_enable, drop_count, truncate_count.
  - slots_free resets to RECEIVE_QUE_SLOTS, and rx_ready to its reset-state value.
  - A partially written frame is abandoned. Downstream FIFOs are flushed by the same reset.

## Timing
- rx_ready is decoded only from registered state. There is no combinational path from rx_data_valid or slot_release.
- Byte accepted at edge k:
  - slot_write_data / slot_write_enable are valid for the cycle after edge k (registered, 1-cycle latency).
  - slot_write_enable is low in every cycle without an accepted, written byte.
- Last byte accepted at edge k: slot_enable[i] rises at edge k+2. This guarantees the byte is in the FIFO before the arbiter sees the slot.
- slot_release[i] sampled at edge k: slot_enable[i] falls and slots_free increments at edge k+1. The slot can be allocated from edge k+2 onward.
- Allocation and release in the same cycle use pre-edge status. A slot being released is not allocatable that cycle.
- Back-to-back frames: a new frame's first byte may be accepted in the cycle after the previous last byte, with no idle cycle.

## Configuration
- RECEIVE_SLOT_ALLOCATOR_DROP_EN defined, in S_IDLE with no FREE slot:
  - rx_ready = 1, and the first byte is accepted.
  - drop_count increments.
  - The FSM goes to S_DISCARD, or stays in S_IDLE if [8] = 1.
  - The stream is never back-pressured between frames.
- Not defined: rx_ready = 0 in S_IDLE while slots_free == 0, so the source stalls until a release. drop_count stays 0.

## Test plan
- Single frame, 4 slots: 5 bytes 0x11..0x15, last on 0x15 → slot 0 is written with 5 strobes, each 1 cycle after acceptance, with [8] set only on 0x15. slot_enable = 4'b0001 from 2 cycles after the last byte. slots_free = 3.
- Round-robin: 4 single-byte frames, then release slot 1, then a fifth frame → slots 0, 1, 2, 3 are allocated in order. The fifth frame goes to slot 1, with no write to slot 0.
- Full queue: fill all 4 slots, then offer a frame. Without the macro: rx_ready = 0 until release of slot 2, then the frame goes to slot 2. With the macro: frame consumed, no write strobe, drop_count = 1.
- Truncation with MAX_FRAME_BYTES = 8: a 12-byte frame → 8 writes, with the 8th carrying [8] = 1. The remaining 4 bytes are consumed without writes. truncate_count = 1.
- Release of a FILLING or FREE slot → no status change. Release and allocation of the same slot in one cycle → that slot is not reallocated that cycle.
- Reset asserted mid-frame at byte 3 → all outputs take their reset values immediately. After deassertion, the next frame goes to slot 0.
